// File: rtl/pd_bus_sizer_if.sv
// pd_bus_sizer_if: host and peripheral bus bundle.
// Master is the host/peripheral side, slave is the sizer.
interface pd_bus_sizer_if;
  logic        req;
  logic        wr;
  logic        sa0;
  logic        sbhe;
  logic [15:0] sd_in;
  logic [15:0] sd_out;
  logic        busy;
  logic        ack;
  logic        pa0;
  logic [7:0]  pd_in;
  logic [7:0]  pd_out;
  logic        pd_oe;
  logic        prd;
  logic        pwr;

  modport master (
    output req, wr, sa0, sbhe, sd_in, pd_in,
    input  sd_out, busy, ack, pa0,
    input  pd_out, pd_oe, prd, pwr
  );

  modport slave (
    input  req, wr, sa0, sbhe, sd_in, pd_in,
    output sd_out, busy, ack, pa0,
    output pd_out, pd_oe, prd, pwr
  );
endinterface

// File: rtl/pd_bus_sizer.sv
// pd_bus_sizer: 16-bit host to 8-bit peripheral bus sequencer.
// One or two byte strobe cycles per access, fixed strobe width.
module pd_bus_sizer #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  pd_bus_sizer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, DONE
  } state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        wr_q;
  logic        two_q;
  logic        second_q;
  logic        pa0_q;
  logic [7:0]  hi_q;
  logic [7:0]  pdo_q;
  logic [15:0] rd_q;
  logic [15:0] sdo_q;
  logic        accept;
  logic        last;
  logic        more;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state, strobes and status from the current state
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    last       = 1'b0;
    more       = two_q && !second_q;
    bus.busy   = (state != IDLE);
    bus.ack    = (state == DONE);
    bus.prd    = (state == STROBE) && !wr_q;
    bus.pwr    = (state == STROBE) && wr_q;
    bus.pd_oe  = wr_q && ((state == SETUP) ||
                          (state == STROBE) ||
                          (state == HOLD));
    bus.pa0    = pa0_q;
    bus.pd_out = pdo_q;
    bus.sd_out = sdo_q;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          accept   = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP:  state_nx = STROBE;
      STROBE: begin
        if (cnt == 4'd0) begin
          last     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD:    state_nx = more ? SETUP : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // access latch, strobe counter, lane steering and read assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      wr_q     <= 1'b0;
      two_q    <= 1'b0;
      second_q <= 1'b0;
      pa0_q    <= 1'b0;
      hi_q     <= 8'h00;
      pdo_q    <= 8'h00;
      rd_q     <= 16'hFFFF;
      sdo_q    <= 16'hFFFF;
    end else begin
      if (accept) begin
        wr_q     <= bus.wr;
        two_q    <= !bus.sbhe && !bus.sa0;
        second_q <= 1'b0;
        pa0_q    <= bus.sa0;
        hi_q     <= bus.sd_in[15:8];
        pdo_q    <= bus.sa0 ? bus.sd_in[15:8]
                            : bus.sd_in[7:0];
        rd_q     <= 16'hFFFF;
      end
      if (state == SETUP) cnt <= WLAST;
      if ((state == STROBE) && !last) cnt <= cnt - 4'd1;
      if (last && !wr_q) begin
        if (pa0_q) rd_q[15:8] <= bus.pd_in;
        else       rd_q[7:0]  <= bus.pd_in;
      end
      if (state == HOLD) begin
        if (more) begin
          second_q <= 1'b1;
          pa0_q    <= 1'b1;
          pdo_q    <= hi_q;
        end else if (!wr_q) begin
          sdo_q <= rd_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_pd_bus_sizer.sv
// tb_pd_bus_sizer: three sizers (W=1,3,15) on shared stimulus,
// table vectors, corner sequences and random accesses vs a model.
module tb_pd_bus_sizer;
  typedef struct packed {
    logic [15:0] sd;
    logic        busy;
    logic        ack;
    logic        pa0;
    logic [7:0]  pdo;
    logic        oe;
    logic        prd;
    logic        pwr;
  } obs_t;

  typedef struct packed {
    logic        wr;
    logic        sa0;
    logic        sbhe;
    logic [15:0] sd;
    logic [7:0]  m0;
    logic [7:0]  m1;
  } acc_t;

  typedef struct {
    acc_t        a;
    logic [15:0] esd;
    int          ack1;
    int          ack3;
    int          ack15;
  } vec_t;

  localparam int   TMAX    = 36;
  localparam obs_t RST_OBS = {16'hFFFF, 14'h0};
  localparam obs_t ALL     = '1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        sa0 = 1'b0;
  logic        sbhe = 1'b0;
  logic [15:0] sd = 16'h0;
  logic [7:0]  mem0 = 8'h0;
  logic [7:0]  mem1 = 8'h0;

  obs_t        obs[3];
  logic [15:0] sdexp[3];
  int          ackt[3];
  int          checks = 0;
  int          failures = 0;
  vec_t        tbl[8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : 15;
    pd_bus_sizer_if bus_i ();
    assign bus_i.req   = req;
    assign bus_i.wr    = wr;
    assign bus_i.sa0   = sa0;
    assign bus_i.sbhe  = sbhe;
    assign bus_i.sd_in = sd;
    assign bus_i.pd_in = bus_i.pa0 ? mem1 : mem0;
    assign obs[g] = {bus_i.sd_out, bus_i.busy,
                     bus_i.ack, bus_i.pa0,
                     bus_i.pd_out, bus_i.pd_oe,
                     bus_i.prd, bus_i.pwr};
    pd_bus_sizer #(.WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i.slave)
    );
  end

  function automatic int wv(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 15;
  endfunction

  function automatic acc_t mk(
    input logic wr_, input logic sa0_, input logic sbhe_,
    input logic [15:0] sd_, input logic [7:0] m0,
    input logic [7:0] m1);
    return {wr_, sa0_, sbhe_, sd_, m0, m1};
  endfunction

  function automatic logic [15:0] rd_of(input acc_t a);
    if (!a.sbhe && !a.sa0) return {a.m1, a.m0};
    return a.sa0 ? {a.m1, 8'hFF} : {8'hFF, a.m0};
  endfunction

  // expected outputs in clock t after acceptance
  function automatic void model(
    input int w, input acc_t a, input logic [15:0] prev,
    input int t, output obs_t e, output obs_t m);
    int   n;
    int   len;
    int   b;
    int   p;
    logic lane;
    n   = (!a.sbhe && !a.sa0) ? 2 : 1;
    len = w + 2;
    b   = (t - 1) / len;
    p   = (t - 1) % len;
    e   = '0;
    m   = '1;
    if (t <= n * len) begin
      lane   = (n == 2) ? (b == 1) : a.sa0;
      e.sd   = prev;
      e.busy = 1'b1;
      e.pa0  = lane;
      e.pdo  = lane ? a.sd[15:8] : a.sd[7:0];
      e.oe   = a.wr;
      e.prd  = !a.wr && p >= 1 && p <= w;
      e.pwr  = a.wr && p >= 1 && p <= w;
      if (!a.wr) m.pdo = '0;
    end else begin
      e.sd = a.wr ? prev : rd_of(a);
      if (t == n * len + 1) begin
        e.busy = 1'b1;
        e.ack  = 1'b1;
      end
      m.pa0 = 1'b0;
      m.pdo = '0;
    end
  endfunction

  task automatic chk_obs(input string nm, input obs_t act,
                         input obs_t exp, input obs_t msk);
    checks++;
    if (((act ^ exp) & msk) != '0) begin
      failures++;
      $display("FAIL %s act=%h exp=%h mask=%h",
               nm, act, exp, msk);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // one access on all three sizers, checked every clock
  task automatic run_access(input acc_t a, input bit junk);
    int   n;
    obs_t e;
    obs_t m;
    n    = (!a.sbhe && !a.sa0) ? 2 : 1;
    req  = 1'b1;
    wr   = a.wr;
    sa0  = a.sa0;
    sbhe = a.sbhe;
    sd   = a.sd;
    mem0 = a.m0;
    mem1 = a.m1;
    for (int g = 0; g < 3; g++) ackt[g] = 0;
    for (int t = 1; t <= TMAX; t++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        model(wv(g), a, sdexp[g], t, e, m);
        chk_obs($sformatf("acc w%0d t%0d", wv(g), t),
                obs[g], e, m);
        if (obs[g].ack && ackt[g] == 0) ackt[g] = t;
      end
      req = 1'b0;
      if (junk && t <= n * 3 + 1 &&
          $urandom_range(0, 1) == 1) begin
        req  = 1'b1;
        wr   = 1'($urandom);
        sa0  = 1'($urandom);
        sbhe = 1'($urandom);
        sd   = 16'($urandom);
      end
    end
    for (int g = 0; g < 3; g++)
      if (!a.wr) sdexp[g] = rd_of(a);
  endtask

  // reset pulsed during the second strobe clock of the W=3 sizer
  task automatic rst_mid(input logic w);
    int nack;
    req  = 1'b1;
    wr   = w;
    sa0  = 1'b0;
    sbhe = 1'b0;
    sd   = 16'hBEEF;
    mem0 = 8'h77;
    mem1 = 8'h66;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_int("rst pre strobe",
            int'(w ? obs[1].pwr : obs[1].prd), 1);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk_obs($sformatf("rst mid w%0d", wv(g)),
              obs[g], RST_OBS, ALL);
    rst  = 1'b0;
    nack = 0;
    repeat (40) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (obs[g].ack) nack++;
    end
    chk_int("rst no ack", nack, 0);
    for (int g = 0; g < 3; g++) sdexp[g] = 16'hFFFF;
  endtask

  initial begin
    int   nack;
    int   a1;
    int   a2;
    int   prdc;
    int   both;
    int   busy12;
    acc_t ra;

    tbl[0] = '{mk(0, 0, 0, 16'h0000, 8'h34, 8'h12),
               16'h1234, 7, 11, 35};
    tbl[1] = '{mk(0, 1, 0, 16'h0000, 8'h00, 8'hA5),
               16'hA5FF, 4, 6, 18};
    tbl[2] = '{mk(1, 0, 0, 16'hBEEF, 8'h00, 8'h00),
               16'hA5FF, 7, 11, 35};
    tbl[3] = '{mk(1, 0, 1, 16'h1357, 8'h00, 8'h00),
               16'hA5FF, 4, 6, 18};
    tbl[4] = '{mk(0, 0, 1, 16'h0000, 8'h5A, 8'hC3),
               16'hFF5A, 4, 6, 18};
    tbl[5] = '{mk(0, 1, 1, 16'h0000, 8'h5A, 8'hC3),
               16'hC3FF, 4, 6, 18};
    tbl[6] = '{mk(1, 1, 0, 16'h2468, 8'h00, 8'h00),
               16'hC3FF, 4, 6, 18};
    tbl[7] = '{mk(1, 1, 1, 16'h9ABC, 8'h00, 8'h00),
               16'hC3FF, 4, 6, 18};

    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk_obs($sformatf("reset w%0d", wv(g)),
              obs[g], RST_OBS, ALL);
      sdexp[g] = 16'hFFFF;
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_access(tbl[i].a, 1'b1);
      for (int g = 0; g < 3; g++)
        chk_int($sformatf("vec%0d sd w%0d", i, wv(g)),
                int'(obs[g].sd), int'(tbl[i].esd));
      chk_int($sformatf("vec%0d ack w1", i),
              ackt[0], tbl[i].ack1);
      chk_int($sformatf("vec%0d ack w3", i),
              ackt[1], tbl[i].ack3);
      chk_int($sformatf("vec%0d ack w15", i),
              ackt[2], tbl[i].ack15);
    end

    // REQ held through two 16-bit reads on the W=3 sizer
    req    = 1'b1;
    wr     = 1'b0;
    sa0    = 1'b0;
    sbhe   = 1'b0;
    mem0   = 8'h34;
    mem1   = 8'h12;
    nack   = 0;
    a1     = 0;
    a2     = 0;
    prdc   = 0;
    both   = 0;
    busy12 = -1;
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      if (obs[1].ack) begin
        nack++;
        if (nack == 1) a1 = t;
        else a2 = t;
      end
      if (obs[1].prd && obs[1].pwr) both++;
      if (obs[1].prd) prdc++;
      if (t == 12) busy12 = int'(obs[1].busy);
      if (t == 20) req = 1'b0;
    end
    chk_int("held acks", nack, 2);
    chk_int("held ack1 clk", a1, 11);
    chk_int("held ack2 clk", a2, 23);
    chk_int("held prd clocks", prdc, 12);
    chk_int("held strobe overlap", both, 0);
    chk_int("held idle clk12", busy12, 0);
    repeat (40) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk_int($sformatf("held sd w%0d", wv(g)),
              int'(obs[g].sd), 16'h1234);
      sdexp[g] = 16'h1234;
    end

    rst_mid(1'b0);
    rst_mid(1'b1);

    // reset wins over a simultaneous request
    rst = 1'b1;
    req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk_obs($sformatf("rst+req w%0d", wv(g)),
              obs[g], RST_OBS, ALL);

    for (int i = 0; i < 40; i++) begin
      ra = mk(1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 8'($urandom), 8'($urandom));
      run_access(ra, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/pd_bus_sizer.md
# pd_bus_sizer

Sequencer between the 16-bit system data bus (SD) and the 8-bit peripheral data bus (PD). It splits each host access into one or two 8-bit PD strobe cycles, steers bytes between the SD lanes and PD, and stretches the strobe by a fixed wait count. It returns assembled read data and a completion pulse. Undriven SD lanes read back as all-ones, matching the bus pull-up convention.

## Interface
- WAIT_CYCLES, 3, PRD/PWR strobe width in clocks; legal range 1..15.
- CLK  in  1  system clock; every register updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  1  host access request; sampled only in IDLE.
- WR  in  1  1 = write, 0 = read; latched with REQ.
- SA0  in  1  byte address bit; latched with REQ.
- SBHE  in  1  active-low byte-high enable; latched with REQ.
- SD_IN  in  16  host write data; latched with REQ.
- SD_OUT  out  16  assembled read data.
- BUSY  out  1  access in progress.
- ACK  out  1  one-clock completion pulse.
- PA0  out  1  peripheral byte address.
- PD_IN  in  8  peripheral read data.
- PD_OUT  out  8  peripheral write data.
- PD_OE  out  1  PD_OUT drive enable; asserted during write cycles only.
- PRD  out  1  peripheral read strobe, active-high.
- PWR  out  1  peripheral write strobe, active-high.

## Operation
- Access width:
  - SBHE=0 and SA0=0: 16-bit access, two byte cycles. Low byte first with PA0=0, then high byte with PA0=1.
  - Any other combination: 8-bit access, one byte cycle with PA0=SA0.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
  - IDLE: on REQ=1, latch WR, SA0, SBHE and SD_IN, then go to SETUP.
  - SETUP, 1 clock: drive PA0. On writes, drive PD_OUT and PD_OE=1.
  - STROBE, WAIT_CYCLES clocks: PRD (read) or PWR (write) is 1. A 4-bit counter counts down.
  - HOLD, 1 clock: strobe is 0. PA0, PD_OUT and PD_OE are held.
    - If a second byte is pending, go to SETUP.
    - Otherwise go to DONE.
  - DONE, 1 clock: ACK=1, PD_OE=0. Go to IDLE.
- Read capture: PD_IN is sampled on the last STROBE clock.
  - 16-bit access: the first byte goes to SD_OUT[7:0], the second to SD_OUT[15:8].
  - 8-bit access, SA0=0: SD_OUT = {8'hFF, byte}.
  - 8-bit access, SA0=1: SD_OUT = {byte, 8'hFF}.
- Write steering:
  - 16-bit access: SD_IN[7:0], then SD_IN[15:8].
  - 8-bit access: SD_IN[7:0] when SA0=0, SD_IN[15:8] when SA0=1.
- SD_OUT update rules:
  - Updated only at DONE of a read.
  - Holds its value until the next read completes.
  - Writes leave it unchanged.
- REQ while BUSY=1 is ignored. No queuing; the host re-asserts REQ.
- BUSY=1 in every state except IDLE.

## Timing
- Reset values: SD_OUT=16'hFFFF; PD_OUT=8'h00; BUSY, ACK, PA0, PD_OE, PRD and PWR all 0. FSM state is IDLE.
- Let REQ be sampled at edge 0.
  - Byte cycle length is W+2 clocks, where W=WAIT_CYCLES.
  - ACK is high in clock n*(W+2)+1, where n is the number of bytes (1 or 2).
  - BUSY is high in clocks 1 through n*(W+2)+1.
  - The earliest next acceptance is at the edge ending clock n*(W+2)+2.
- PRD and PWR are never both 1. A strobe is never 1 outside STROBE.
- PA0 and PD_OUT are stable from SETUP through HOLD of each byte cycle.
- RST=1 mid-access:
  - All outputs return to reset values at the next edge, including strobes and PD_OE.
  - No ACK is issued; the access is abandoned.
- RST and REQ high together: RST wins; the request is dropped.

## Test plan
- W=3, 16-bit read (SBHE=0, SA0=0), PD_IN=8'h34 in byte cycle 1 and 8'h12 in byte cycle 2:
  - PA0 is 0 then 1, each PRD pulse is 3 clocks wide.
  - ACK in clock 11, SD_OUT=16'h1234, BUSY high in clocks 1-11.
- W=3, 8-bit read (SBHE=0, SA0=1), PD_IN=8'hA5:
  - A single PRD pulse with PA0=1.
  - ACK in clock 6, SD_OUT=16'hA5FF.
- W=1, 16-bit write SD_IN=16'hBEEF:
  - PD_OUT is 8'hEF with PA0=0, then 8'hBE with PA0=1.
  - Each PWR pulse is 1 clock, PD_OE=0 in clock 7, ACK in clock 7, SD_OUT unchanged.
- REQ held high continuously through two 16-bit reads:
  - The second access starts at the edge after the first access's DONE clock.
  - No overlap of strobes; exactly two ACK pulses.
- W=3, RST pulsed during the second PRD clock of a 16-bit read:
  - At the next edge: PRD=0, BUSY=0, SD_OUT=16'hFFFF, and no ACK follows.
- W=15, 8-bit write (SBHE=1, SA0=0):
  - PWR is high for exactly 15 clocks.
  - ACK in clock 18; REQ pulses during BUSY are ignored.
